// File: rtl/count_seq_checker.sv
// Consumer-side checker for a free-running modulo-2^WIDTH up-counter bus.
// Optional macro COUNT_SEQ_CHECKER_HOLD_EN accepts a repeated (held) value as a no-op.
module count_seq_checker #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned ERR_W  = 8,
    parameter int unsigned LOCK_N = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] count_in,
    input  logic             sample_en,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic [ERR_W-1:0] wrap_count,
    output logic [WIDTH-1:0] expected
);

    typedef enum logic [1:0] {IDLE, ACQ, LOCKED} state_t;

    localparam logic [3:0] LOCK_RUN = 4'(LOCK_N);

    state_t           state;
    logic [3:0]       run;
    logic [WIDTH-1:0] next_val;
    logic             hit;
    logic             held;

    assign next_val = count_in + 1'b1;
    assign hit      = (count_in == expected);

`ifdef COUNT_SEQ_CHECKER_HOLD_EN
    assign held = (state != IDLE) && (count_in == expected - 1'b1);
`else
    assign held = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            run        <= '0;
            locked     <= 1'b0;
            err_pulse  <= 1'b0;
            err_count  <= '0;
            wrap_count <= '0;
            expected   <= '0;
        end else begin
            err_pulse <= 1'b0;
            if (clear) begin
                state      <= IDLE;
                run        <= '0;
                locked     <= 1'b0;
                err_count  <= '0;
                wrap_count <= '0;
                expected   <= '0;
            end else if (sample_en) begin
                case (state)
                    IDLE: begin
                        expected <= next_val;
                        run      <= 4'd1;
                        if (LOCK_N <= 1) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end else begin
                            state <= ACQ;
                        end
                    end
                    ACQ: begin
                        if (hit) begin
                            run      <= run + 4'd1;
                            expected <= expected + 1'b1;
                            // >= rather than == so LOCK_N=1 can still relock after a break
                            if ((run + 4'd1) >= LOCK_RUN) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end
                        end else if (!held) begin
                            expected <= next_val;
                            run      <= 4'd1;
                        end
                    end
                    LOCKED: begin
                        if (hit) begin
                            expected <= expected + 1'b1;
                            if (count_in == '0 && wrap_count != '1)
                                wrap_count <= wrap_count + 1'b1;
                        end else if (!held) begin
                            err_pulse <= 1'b1;
                            if (err_count != '1)
                                err_count <= err_count + 1'b1;
                            expected <= next_val;
                            run      <= 4'd1;
                            state    <= ACQ;
                            locked   <= 1'b0;
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/count_seq_checker.md
# count_seq_checker

Stream-side checker for the free-running up-counter bus (`count`). It samples the counter output each qualified clock and acquires lock on the sequence. Once locked, it flags every break in the modulo-2^WIDTH increment and keeps saturating error and wrap statistics. It sits beside the counter in the same clock domain and is instantiated by benches and by on-chip self-test as the consumer end of the count interface.

## Interface
- `WIDTH`, 4: count bus width.
- `ERR_W`, 8: width of error and wrap statistics counters.
- `LOCK_N`, 2: consecutive correct samples needed to lock (1..15).

- `clk`  in  1: rising-edge clock.
- `reset`  in  1: asynchronous, active-low reset.
- `count_in`  in  WIDTH: counter value under check.
- `sample_en`  in  1: qualifies `count_in` this cycle.
- `clear`  in  1: synchronous clear of state and statistics.
- `locked`  out  1: sequence locked.
- `err_pulse`  out  1: one-cycle pulse per in-lock mismatch.
- `err_count`  out  ERR_W: saturating mismatch count.
- `wrap_count`  out  ERR_W: saturating in-lock wrap count.
- `expected`  out  WIDTH: next value the checker expects.

## Operation
- FSM states: IDLE, ACQ, LOCKED. Reset state is IDLE.
- All outputs are 0 while `reset` is low.
- Samples are evaluated only when `sample_en`=1. Cycles with `sample_en`=0 leave all state unchanged, and `err_pulse` is 0.
- IDLE, on a sample:
  - `expected` <= `count_in`+1 (mod 2^WIDTH).
  - `run` <= 1.
  - Go to ACQ, or directly to LOCKED if `LOCK_N`=1.
- ACQ, sample equal to `expected`:
  - `run`++ and `expected`++.
  - When `run`+1 == `LOCK_N`, go to LOCKED.
- ACQ, sample not equal to `expected`:
  - Resync: `expected` <= `count_in`+1, `run` <= 1.
  - No error is counted in ACQ.
- LOCKED, match: `expected`++. If the matched value is 0, `wrap_count`++.
- LOCKED, mismatch:
  - `err_pulse`=1 and `err_count`++.
  - Resync `expected` as in ACQ and go to ACQ. `locked` drops.
- Statistics saturate at 2^ERR_W−1 and never wrap.
- `clear`=1 forces IDLE, zeroes `run`, statistics, `expected` and `err_pulse`. `clear` has priority over a simultaneous sample.
- Reset mid-operation: asynchronous return to IDLE with all outputs 0. The next post-reset sample re-acquires.
- Width rule: `expected` arithmetic is WIDTH bits, so all-ones +1 = 0 with no carry out.

## Timing
- All outputs are registered.
- A sample at edge N affects `expected`, `locked`, `err_pulse` and statistics visible after edge N.
- `err_pulse` is high exactly one cycle per mismatch. Back-to-back mismatches in LOCKED are impossible because the first mismatch moves the FSM to ACQ.
- Lock latency: `locked` rises after the `LOCK_N`th consecutive good sample, counting the IDLE capture as the first.
- Release of `reset` takes effect on the first rising edge where it is sampled high. There is no synchronizer inside the block.

## Configuration
- Macro `COUNT_SEQ_CHECKER_HOLD_EN`.
- Defined: in ACQ or LOCKED, a sample equal to `expected`−1 (the counter held) is accepted as a no-op. There is no resync, no error, and `run` and `expected` are unchanged. This supports counters with a count-enable.
- Undefined: a held value is an ordinary mismatch.

## Test plan
- Reset low for 2 cycles, then samples 0..15, 0..3 with `LOCK_N`=2 -> `locked`=1 after the sample of 1; `wrap_count`=1 after the second 0; `err_count`=0; `expected`=4 at end.
- Locked at 5, then inject 9 -> one-cycle `err_pulse`, `err_count`=1, `locked`=0, `expected`=10; then 10 relocks.
- Sample 15 then 0 while locked -> `wrap_count` increments, no error, `expected`=1.
- Force 300 mismatches with `ERR_W`=8, for example by alternating relock and corruption -> `err_count` holds at 255.
- `clear` asserted on the same cycle as a valid sample -> IDLE, all statistics 0, sample ignored. `reset` pulsed low mid-count -> outputs 0 immediately, and the next samples re-acquire.
- Repeat value 7 twice while locked -> with `COUNT_SEQ_CHECKER_HOLD_EN` there is no error and `locked` stays 1; without it `err_count`=1.
